binarize_scanner: RTL
=====================

BINARIZE_SCANNER -- requirements
Module: binarize_scanner

Interface
REQ-001 Parameter WIDTH_BITS, default 7; log2 of image width (128).
REQ-002 Parameter HEIGHT_BITS, default 7; log2 of image height (128).
REQ-003 Parameter RD_LATENCY, default 2; cycles from oCol/oRow to valid iPixel/iThreshold (ROM read plus reader output register).
REQ-004 clock  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 iStart  in  1  one-cycle request to scan one frame; honoured only in IDLE.
REQ-007 iInvert  in  1  0: white = pixel > threshold; 1: white = pixel <= threshold; sampled at frame start.
REQ-008 oCol  out  WIDTH_BITS  column address driven to the pixel and threshold readers.
REQ-009 oRow  out  HEIGHT_BITS  row address driven to the pixel and threshold readers.
REQ-010 iPixel  in  8  pixel value, RD_LATENCY cycles after its address.
REQ-011 iThreshold  in  8  threshold value, RD_LATENCY cycles after its address.
REQ-012 oValid  out  1  oBin/oX/oY carry a result this cycle.
REQ-013 oBin  out  1  binarized pixel.
REQ-014 oX  out  WIDTH_BITS  column of the oBin result.
REQ-015 oY  out  HEIGHT_BITS  row of the oBin result.
REQ-016 oBusy  out  1  high in every state except IDLE.
REQ-017 oDone  out  1  one-cycle pulse after the last result of a frame.

Function
REQ-018 The FSM SHALL have the states IDLE, SCAN, DRAIN, and DONE.
REQ-019 IDLE -> SCAN on iStart; oCol = oRow = 0 on entry; iInvert latched.
REQ-020 In SCAN, the block SHALL issue one address per cycle in raster order: oCol increments, wraps to 0 at 2^WIDTH_BITS-1, and oRow increments on the wrap.
REQ-021 SCAN -> DRAIN in the cycle after address (max, max) is issued; addresses hold at (0, 0) in DRAIN, DONE and IDLE.
REQ-022 DRAIN SHALL last exactly RD_LATENCY+1 cycles, then move to DONE.
REQ-023 DONE SHALL assert oDone for one cycle, then return to IDLE.
REQ-024 A delay line of RD_LATENCY stages SHALL carry the issue flag, column and row alongside each read so they align with iPixel/iThreshold.
REQ-025 Outputs SHALL be registered: a result appears on oValid/oBin/oX/oY exactly RD_LATENCY+1 cycles after its address.
REQ-026 The comparison SHALL be an unsigned 8-bit comparison; equality gives 0 when iInvert=0 and 1 when iInvert=1.
REQ-027 Each frame SHALL produce exactly 2^(WIDTH_BITS+HEIGHT_BITS) oValid cycles, contiguous, with no gaps.
REQ-028 iStart while not in IDLE SHALL be ignored; it is not queued.
REQ-029 The last oValid SHALL occur in the cycle before oDone.
REQ-030 iStart in the same cycle as oDone SHALL be ignored; the earliest restart is the following cycle.

Reset
REQ-031 Assertion of reset_n at any time, including mid-frame, SHALL force: state IDLE; oCol, oRow, oX, oY = 0; oValid, oBin, oBusy, oDone = 0; the delay line and the latched invert cleared.
REQ-032 After reset release, no oValid SHALL appear until a new iStart.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding and the default WIDTH_BITS, HEIGHT_BITS and RD_LATENCY values.
REQ-034 One sub-module, raster_counter, SHALL hold the col/row counter with enable, clear and last-pixel flag; the delay line and comparator stay inline.

Verification
REQ-035 Reset then iStart with a pixel model of x+y and a threshold model of 128 -> 16384 contiguous oValid; oBin = 1 exactly where x+y > 128; oDone one cycle after the last.
REQ-036 Raster check -> first result oX=0, oY=0 at start+RD_LATENCY+2 cycles; result 128 is (0,1); last result is (127,127).
REQ-037 pixel == threshold = 100 everywhere, iInvert=0 then a second frame with iInvert=1 -> all oBin=0, then all oBin=1; iInvert toggled mid-frame has no effect.
REQ-038 iStart pulsed during SCAN and on the oDone cycle -> only one frame produced; iStart the cycle after oDone starts a new frame.
REQ-039 reset_n low at result 5000 -> all outputs 0 within the reset cycle; after release, no oValid without a new iStart, and a full frame is produced afterwards.
REQ-040 WIDTH_BITS=3, HEIGHT_BITS=2, RD_LATENCY=1 -> 32 results, with oDone at the cycle after result 31.

Source files
------------

// File: rtl/binarize_scanner_pkg.sv
// Shared definitions for the frame binarizer: FSM encoding and default geometry/latency.
package binarize_scanner_pkg;

  localparam int DEF_WIDTH_BITS  = 7;
  localparam int DEF_HEIGHT_BITS = 7;
  localparam int DEF_RD_LATENCY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row address counter with clear, enable and last-pixel flag.
module raster_counter #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   clr,
  output logic [WIDTH_BITS-1:0]  col,
  output logic [HEIGHT_BITS-1:0] row,
  output logic                   last
);

  logic [WIDTH_BITS-1:0]  col_q, col_d;
  logic [HEIGHT_BITS-1:0] row_q, row_d;

  // Incrementing past (max,max) wraps both fields to zero on its own.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      col_d = col_q + 1'b1;
      if (col_q == '1) row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == '1) && (row_q == '1);

endmodule

// File: rtl/binarize_scanner.sv
// Scans one frame in raster order, thresholds each returned pixel and emits
// registered (bin, x, y) results with one-cycle done pulse at frame end.
module binarize_scanner
  import binarize_scanner_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iStart,
  input  logic                   iInvert,
  output logic [WIDTH_BITS-1:0]  oCol,
  output logic [HEIGHT_BITS-1:0] oRow,
  input  logic [7:0]             iPixel,
  input  logic [7:0]             iThreshold,
  output logic                   oValid,
  output logic                   oBin,
  output logic [WIDTH_BITS-1:0]  oX,
  output logic [HEIGHT_BITS-1:0] oY,
  output logic                   oBusy,
  output logic                   oDone
);

  localparam int DW = $clog2(RD_LATENCY + 2);

  state_t           state_q, state_d;
  logic             inv_q, inv_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             cnt_en, cnt_clr, last_pix, issue;

  logic [RD_LATENCY:1]                  vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY:1][WIDTH_BITS-1:0]  col_pipe_q, col_pipe_d;
  logic [RD_LATENCY:1][HEIGHT_BITS-1:0] row_pipe_q, row_pipe_d;

  logic                   valid_q, valid_d;
  logic                   bin_q, bin_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d;

  raster_counter #(
    .WIDTH_BITS  (WIDTH_BITS),
    .HEIGHT_BITS (HEIGHT_BITS)
  ) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .col     (oCol),
    .row     (oRow),
    .last    (last_pix)
  );

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    drain_d = drain_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (iStart) begin
          state_d = ST_SCAN;
          inv_d   = iInvert;
        end
      end
      ST_SCAN: begin
        issue  = 1'b1;
        cnt_en = 1'b1;
        if (last_pix) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      // Covers the read latency plus the output register.
      ST_DRAIN: begin
        if (drain_q == DW'(RD_LATENCY)) state_d = ST_DONE;
        else                            drain_d = drain_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    col_pipe_d    = col_pipe_q;
    row_pipe_d    = row_pipe_q;
    vld_pipe_d[1] = issue;
    col_pipe_d[1] = oCol;
    row_pipe_d[1] = oRow;
    for (int i = 2; i <= RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      col_pipe_d[i] = col_pipe_q[i-1];
      row_pipe_d[i] = row_pipe_q[i-1];
    end
  end

  // Final stage lines up with iPixel/iThreshold for the same address.
  always_comb begin
    valid_d = vld_pipe_q[RD_LATENCY];
    bin_d   = vld_pipe_q[RD_LATENCY] &
              (inv_q ? (iPixel <= iThreshold) : (iPixel > iThreshold));
    x_d     = col_pipe_q[RD_LATENCY];
    y_d     = row_pipe_q[RD_LATENCY];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      inv_q      <= 1'b0;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      col_pipe_q <= '0;
      row_pipe_q <= '0;
      valid_q    <= 1'b0;
      bin_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      inv_q      <= inv_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      col_pipe_q <= col_pipe_d;
      row_pipe_q <= row_pipe_d;
      valid_q    <= valid_d;
      bin_q      <= bin_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign oValid = valid_q;
  assign oBin   = bin_q;
  assign oX     = x_q;
  assign oY     = y_q;
  assign oBusy  = (state_q != ST_IDLE);
  assign oDone  = (state_q == ST_DONE);

endmodule
